// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC-V core: sequences the shared ALU,
// the unified memory port and the register file over several cycles per instruction.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       imm_sgn,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       result_src,
  output logic             illegal_instr,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic [2:0] fn_ctrl;
  logic       fn_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ALU function for EXECR/EXECI; only add/sub/slt/or/and are supported.
  always_comb begin
    fn_ctrl  = ALU_ADD;
    fn_legal = 1'b1;
    case (funct3)
      3'b000:  fn_ctrl = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  fn_ctrl = ALU_SLT;
      3'b110:  fn_ctrl = ALU_OR;
      3'b111:  fn_ctrl = ALU_AND;
      default: fn_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    imm_sgn       = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    instr_retired = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute oldPC + imm so branch/jal targets sit in the ALU-out register.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_sgn   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_sgn    = {1'b0, opcode[5]};
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_next    = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_ctrl   = fn_ctrl;
        state_next = fn_legal ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        // Only beq/bne exist; funct3[0] inverts the equality test.
        if (funct3[2:1] == 2'b00) begin
          pc_write      = zero ^ funct3[0];
          instr_retired = 1'b1;
          state_next    = S_FETCH;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: illegal_instr = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (instr_retired) begin
      retired_cnt <= retired_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream compared against a per-instruction behavioural model.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       imm_sgn;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       result_src;
  logic             illegal_instr;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  // Observations gathered over one instruction
  int ob_cycles, ob_rw, ob_pw, ob_we, ob_viol, ob_imm0, ob_imm1, ob_alu1, ob_pw1;
  int ob_rs_last;
  bit ob_done, ob_trap;

  // Expected values from the model
  int ex_cycles, ex_rw, ex_pw, ex_we, ex_imm0, ex_imm1, ex_alu1, ex_pw1;
  bit ex_trap;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_sgn(imm_sgn), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .illegal_instr(illegal_instr), .instr_retired(instr_retired),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] all_outs();
    return {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_sgn, alu_src_a,
            alu_src_b, alu_ctrl, result_src, illegal_instr, instr_retired, retired_cnt};
  endfunction

  // Instruction-level model: cycle count, enable totals and a few per-phase values.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int fw, input int dw);
    int fn;
    fn = (f3 == 3'b000) ? 0 : (f3 == 3'b010) ? 5 : (f3 == 3'b110) ? 3 : (f3 == 3'b111) ? 2 : -1;
    ex_rw = 0; ex_we = 0; ex_pw = 1; ex_imm1 = 0; ex_alu1 = 0; ex_pw1 = 0; ex_trap = 0;
    ex_imm0 = (op == 7'b1101111) ? 3 : 2;
    ex_cycles = 1 + fw;
    case (op)
      7'b0000011: begin ex_cycles += 4 + dw; ex_rw = 1; end
      7'b0100011: begin ex_cycles += 3 + dw; ex_we = 1 + dw; ex_imm1 = 1; end
      7'b0110011, 7'b0010011: begin
        if (fn < 0) begin ex_cycles += 2; ex_trap = 1; end
        else begin
          ex_cycles += 3; ex_rw = 1;
          ex_alu1 = (fn == 0 && op == 7'b0110011 && f7) ? 1 : fn;
        end
      end
      7'b1100011: begin
        ex_alu1 = 1;
        if (f3 > 3'd1) begin ex_cycles += 2; ex_trap = 1; end
        else begin ex_cycles += 2; ex_pw1 = int'(z ^ f3[0]); ex_pw += ex_pw1; end
      end
      7'b1101111: begin ex_cycles += 3; ex_rw = 1; ex_pw1 = 1; ex_pw = 2; end
      default: begin ex_cycles += 1; ex_trap = 1; end
    endcase
  endtask

  // Drives one instruction from its FETCH cycle until it retires or traps,
  // acting as a memory with fw fetch and dw data wait cycles.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int dw);
    int fl, dl, k;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    fl = fw; dl = dw; k = -1;
    ob_cycles = 0; ob_rw = 0; ob_pw = 0; ob_we = 0; ob_viol = 0;
    ob_imm0 = -1; ob_imm1 = -1; ob_alu1 = -1; ob_pw1 = -1; ob_rs_last = -1;
    ob_done = 0; ob_trap = 0;
    for (int c = 0; c < 40 && !ob_done; c++) begin
      if (mem_req) begin
        if (adr_src ? (dl > 0) : (fl > 0)) begin
          mem_ready = 1'b0;
          if (adr_src) dl--; else fl--;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      ob_cycles++;
      if (mem_req && !mem_ready && (ir_write || pc_write || reg_write || instr_retired)) ob_viol++;
      if (reg_write) ob_rw++;
      if (pc_write) ob_pw++;
      if (mem_we) ob_we++;
      if (k == 0) ob_imm0 = int'(imm_sgn);
      if (k == 1) begin ob_imm1 = int'(imm_sgn); ob_alu1 = int'(alu_ctrl); ob_pw1 = int'(pc_write); end
      if (k >= 0) k++;
      if (ir_write) k = 0;
      if (reg_write) ob_rs_last = int'(result_src);
      if (instr_retired) begin ob_done = 1; exp_cnt = (exp_cnt + 1) % (1 << CNT_W); end
      if (illegal_instr) begin ob_done = 1; ob_trap = 1; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 0; zero = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs() !== 26'd0) begin
      n_fail++; $display("FAIL reset_hold: outputs=%h required 0", all_outs());
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: mem_req=%b required 0", mem_req); end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_wait_req: mem_req=%b required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 26'd0) begin
      n_fail++; $display("FAIL reset_midfetch: outputs=%h required 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: mem_req=%b required 0", mem_req); end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || adr_src !== 1'b0) begin
      n_fail++; $display("FAIL first_fetch: mem_req=%b adr_src=%b required 1/0", mem_req, adr_src);
    end
    @(negedge clk);
    $display("reset: done, outputs idle=%0d", mem_req);
  endtask

  task automatic test_lw();
    exec_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
    $display("lw: cycles=%0d cnt=%0d", ob_cycles, retired_cnt);
    n_checks++;
    if (ob_cycles !== 5 || ob_done !== 1'b1) begin
      n_fail++; $display("FAIL lw_cycles: got %0d required 5", ob_cycles);
    end
    n_checks++;
    if (ob_imm1 !== 0 || ob_rs_last !== 1) begin
      n_fail++; $display("FAIL lw_fields: imm=%0d result_src=%0d required 0/1", ob_imm1, ob_rs_last);
    end
    n_checks++;
    if (retired_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL lw_count: got %0d required 1", retired_cnt);
    end
  endtask

  task automatic test_sw_wait();
    exec_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
    $display("sw: cycles=%0d mem_we_cycles=%0d", ob_cycles, ob_we);
    n_checks++;
    if (ob_cycles !== 7 || ob_we !== 4) begin
      n_fail++; $display("FAIL sw_wait: cycles=%0d we=%0d required 7/4", ob_cycles, ob_we);
    end
    n_checks++;
    if (ob_imm1 !== 1 || ob_rw !== 0 || ob_viol !== 0) begin
      n_fail++; $display("FAIL sw_fields: imm=%0d rw=%0d viol=%0d required 1/0/0", ob_imm1, ob_rw, ob_viol);
    end
  endtask

  task automatic test_branches();
    for (int b = 0; b < 2; b++) begin
      exec_instr(7'b1100011, 3'(b), 1'b0, 1'b1, 0, 0);
      $display("branch f3=%0d zero=1: cycles=%0d pc_write=%0d", b, ob_cycles, ob_pw1);
      n_checks++;
      if (ob_cycles !== 3 || ob_pw1 !== 1 - b || ob_alu1 !== 1) begin
        n_fail++; $display("FAIL branch_%0d: cycles=%0d pcw=%0d alu=%0d required 3/%0d/1",
                           b, ob_cycles, ob_pw1, ob_alu1, 1 - b);
      end
    end
  endtask

  task automatic test_jal_rtype();
    exec_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1, 0);
    $display("jal: cycles=%0d imm0=%0d", ob_cycles, ob_imm0);
    n_checks++;
    if (ob_cycles !== 5 || ob_imm0 !== 3 || ob_pw1 !== 1 || ob_rw !== 1 || ob_rs_last !== 0) begin
      n_fail++; $display("FAIL jal: cycles=%0d imm0=%0d pcw=%0d rw=%0d required 5/3/1/1",
                         ob_cycles, ob_imm0, ob_pw1, ob_rw);
    end
    exec_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    $display("sub: alu_ctrl=%0d", ob_alu1);
    n_checks++;
    if (ob_alu1 !== 1 || ob_cycles !== 4) begin
      n_fail++; $display("FAIL rtype_sub: alu=%0d cycles=%0d required 1/4", ob_alu1, ob_cycles);
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3);
    int cnt_before, bad;
    do_reset();
    exec_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);
    cnt_before = exp_cnt;
    exec_instr(op, f3, 1'b0, 1'b0, 0, 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_req || !illegal_instr || instr_retired || pc_write || reg_write) bad++;
      @(negedge clk);
    end
    $display("illegal op=%b f3=%b: trap=%0d bad_cycles=%0d cnt=%0d", op, f3, ob_trap, bad, retired_cnt);
    n_checks++;
    if (ob_trap !== 1'b1 || bad !== 0) begin
      n_fail++; $display("FAIL illegal_trap: trap=%0d bad=%0d required 1/0", ob_trap, bad);
    end
    n_checks++;
    if (retired_cnt !== CNT_W'(cnt_before)) begin
      n_fail++; $display("FAIL illegal_count: got %0d required %0d", retired_cnt, cnt_before);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) exec_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (retired_cnt !== CNT_W'(exp_cnt) || exp_cnt != 15) begin
      n_fail++; $display("FAIL wrap_max: got %0d required 15", retired_cnt);
    end
    exec_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
    $display("wrap: cnt=%0d", retired_cnt);
    n_checks++;
    if (retired_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++; $display("FAIL wrap_zero: got %0d required %0d", retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[6];
    logic [2:0] alu_f3[4];
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z;
    int fw, dw;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    alu_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 5)];
      f3 = (op == 7'b1100011) ? 3'($urandom_range(0, 1)) : alu_f3[$urandom_range(0, 3)];
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      model(op, f3, f7, z, fw, dw);
      exec_instr(op, f3, f7, z, fw, dw);
      $display("rand %0d: op=%b f3=%b f7=%0d z=%0d fw=%0d dw=%0d cycles=%0d cnt=%0d",
               i, op, f3, f7, z, fw, dw, ob_cycles, retired_cnt);
      n_checks++;
      if (ob_cycles !== ex_cycles || ob_trap !== ex_trap || ob_done !== 1'b1) begin
        n_fail++; $display("FAIL rand_cycles: got %0d required %0d", ob_cycles, ex_cycles);
      end
      n_checks++;
      if (ob_rw !== ex_rw || ob_pw !== ex_pw || ob_we !== ex_we || ob_viol !== 0) begin
        n_fail++; $display("FAIL rand_enables: rw=%0d pw=%0d we=%0d viol=%0d required %0d/%0d/%0d/0",
                           ob_rw, ob_pw, ob_we, ob_viol, ex_rw, ex_pw, ex_we);
      end
      n_checks++;
      if (ob_imm0 !== ex_imm0 || ob_imm1 !== ex_imm1 || ob_alu1 !== ex_alu1 || ob_pw1 !== ex_pw1) begin
        n_fail++; $display("FAIL rand_fields: imm0=%0d imm1=%0d alu=%0d pcw=%0d required %0d/%0d/%0d/%0d",
                           ob_imm0, ob_imm1, ob_alu1, ob_pw1, ex_imm0, ex_imm1, ex_alu1, ex_pw1);
      end
      n_checks++;
      if (retired_cnt !== CNT_W'(exp_cnt)) begin
        n_fail++; $display("FAIL rand_count: got %0d required %0d", retired_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branches();
    test_jal_rtype();
    test_illegal(7'b1111111, 3'b000);
    test_illegal(7'b0010011, 3'b001);
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle variant of the RISC-V core. It sequences one shared ALU, one shared instruction/data memory port and the register file across several cycles per instruction. Each cycle it drives datapath selects, write enables and `imm_sgn`, which is the immediate-extender format select. It sits between the instruction register and the datapath, and waits on a ready/request handshake with a variable-latency memory.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 7: `instr[6:0]` from the instruction register.
- `funct3`, in, 3: `instr[14:12]`.
- `funct7b5`, in, 1: `instr[30]`.
- `zero`, in, 1: ALU zero flag, valid in the cycle it is used.
- `mem_ready`, in, 1: memory completes the current transaction this cycle.
- `mem_req`, out, 1: memory access request.
- `mem_we`, out, 1: write strobe, qualified by `mem_req`.
- `adr_src`, out, 1: memory address select. 0 = PC, 1 = ALU-out register.
- `ir_write`, out, 1: load the instruction register and old-PC register.
- `pc_write`, out, 1: load PC from the result bus.
- `reg_write`, out, 1: register-file write enable.
- `imm_sgn`, out, 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_src_a`, out, 2: ALU operand A. 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`, out, 2: ALU operand B. 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_ctrl`, out, 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `result_src`, out, 2: result bus. 00 = ALU-out register, 01 = read data, 10 = ALU result.
- `illegal_instr`, out, 1: sticky flag, set on an undecodable instruction.
- `instr_retired`, out, 1: one-cycle pulse when an instruction completes.
- `retired_cnt`, out, `CNT_W`: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- The state register resets asynchronously to IDLE.
- Outputs are decoded from the state plus instruction fields (Moore/Mealy mix as listed below).
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH on the next clock edge.
- FETCH:
  - `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
  - `ir_write`=1 and `pc_write`=1 only in the cycle `mem_ready`=1; that cycle moves to DECODE.
  - Otherwise the state stays in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, add, to precompute the target. `imm_sgn`=11 if opcode is 1101111, else 10. Next state by opcode:
  - 0000011 or 0100011 goes to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL.
  - Anything else goes to TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. `imm_sgn`=01 if opcode[5]=1, else 00. Next state is MEMWRITE if opcode[5]=1, else MEMREAD.
- MEMREAD: `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Goes to FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. Holds until `mem_ready`, then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, function decode applies. Goes to ALUWB.
- EXECI: as EXECR but `alu_src_b`=01 and `imm_sgn`=00. Goes to ALUWB.
- Function decode (EXECR/EXECI):
  - funct3 000: sub if EXECR and `funct7b5`=1, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3 goes to TRAP instead of ALUWB, with no write.
- ALUWB: `result_src`=00, `reg_write`=1. Goes to FETCH.
- BRANCH:
  - `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`, covering beq/bne.
  - funct3 other than 000/001 goes to TRAP.
  - Otherwise goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1. Goes to ALUWB, which writes old PC+4.
- TRAP: `illegal_instr`=1, all enables 0. Absorbing until reset.
- `instr_retired` pulses in the final cycle of MEMWB, ALUWB, BRANCH, and in the completing cycle of MEMWRITE.
- `retired_cnt` increments on every `instr_retired` pulse and wraps modulo 2^`CNT_W`.

## Timing
- While `rst_n`=0, all outputs are 0 and `retired_cnt`=0, including `mem_req`.
- Reset asserted mid-transaction drops `mem_req` asynchronously and abandons the access.
- Latency from reset release: first FETCH request 1 cycle after the first edge with `rst_n`=1.
- Cycles per instruction with zero-wait memory (`mem_ready` already high):
  - lw 5, sw 4, R/I 4, branch 3, jal 4.
- Each memory wait cycle adds 1.
- Handshake: while waiting, `mem_req`, `mem_we` and `adr_src` stay constant, and no enables fire.
- A transfer completes in the cycle with `mem_req`=1 and `mem_ready`=1.
- `mem_ready` outside a request is ignored.
- `instr_retired` and the counter update occur in the same cycle; the count is visible on the next edge.

## Test plan
- Reset/idle: hold `rst_n`=0 mid-FETCH with `mem_ready`=0 → all outputs 0 immediately. Release → IDLE, then FETCH with `mem_req`=1.
- lw, zero wait: opcode 0000011 → state sequence FETCH, DECODE, MEMADR (`imm_sgn`=00), MEMREAD, MEMWB (`reg_write`=1, `result_src`=01). 5 cycles, `retired_cnt` 0→1.
- sw with 3 wait cycles: opcode 0100011 → `imm_sgn`=01 in MEMADR. `mem_we`=1 held stable for 4 cycles, 7 cycles total, no `reg_write`.
- Branches: beq with `zero`=1 → `pc_write`=1 in BRANCH. bne with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- jal: opcode 1101111 → `imm_sgn`=11 in DECODE, `pc_write`=1 in JAL, `reg_write`=1 in ALUWB. R-type add with `funct7b5`=1 → `alu_ctrl`=001.
- Illegal: opcode 1111111, or I-type funct3=001 → TRAP, `illegal_instr`=1 sticky, `mem_req`=0 forever, count unchanged. Separately, force `retired_cnt`=2^`CNT_W`−1, retire one instruction → wraps to 0.
